// File: rtl/pll_ctrl_pkg.sv
// Shared types for the rPLL dynamic-reconfiguration controller.
//   pll_state_e : controller FSM states
//   pll_cfg_t   : one divider/phase/duty configuration as seen by the rPLL
//   encode_cfg  : converts a user configuration to rPLL select encoding
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT_LOCK,
    ST_QUALIFY,
    ST_LOCKED,
    ST_FAIL
  } pll_state_e;

  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [5:0] odsel;
    logic [3:0] psda;
    logic [3:0] dutyda;
  } pll_cfg_t;

  // The rPLL IDSEL/FBDSEL dynamic inputs are active-low versions of the
  // static IDIV_SEL/FBDIV_SEL values; everything else passes straight through.
  function automatic pll_cfg_t encode_cfg(input pll_cfg_t cfg);
    pll_cfg_t enc;
    enc       = cfg;
    enc.idiv  = ~cfg.idiv;
    enc.fbdiv = ~cfg.fbdiv;
    return enc;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both stages to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output (2 clk cycles of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Run-time controller for the GW1NR-9C rPLL dynamic-configuration port.
// Sequences PLL reset, lock acquisition, lock qualification, timeout/retry
// and lock-loss recovery, and accepts new divider settings over a
// valid/ready port. Runs on the board clock that feeds the PLL CLKIN.
//   clk, rst                : board clock, asynchronous active-high reset
//   req_valid / req_ready   : configuration request handshake
//   req_idiv .. req_dutyda  : requested configuration (plain, not inverted)
//   pll_lock                : raw rPLL LOCK (asynchronous)
//   pll_reset, pll_reset_p  : rPLL RESET / RESET_P
//   pll_idsel .. pll_fdly   : rPLL dynamic selects
//   locked, busy            : qualified lock / reconfiguration in progress
//   err_timeout             : sticky failure after all retries exhausted
//   lock_lost_cnt           : saturating count of lock losses while locked
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  BOOT_IDIV    = 6'd1,
  parameter logic [5:0]  BOOT_FBDIV   = 6'd10,
  parameter logic [5:0]  BOOT_ODSEL   = 6'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idiv,
  input  logic [5:0] req_fbdiv,
  input  logic [5:0] req_odsel,
  input  logic [3:0] req_psda,
  input  logic [3:0] req_dutyda,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  output logic [3:0] pll_fdly,
  output logic       locked,
  output logic       busy,
  output logic       err_timeout,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SB_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned AT_W = $clog2(MAX_RETRY + 1);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SB_W-1:0] SB_LAST = SB_W'(LOCK_STABLE - 1);
  localparam logic [AT_W-1:0] AT_MAX  = AT_W'(MAX_RETRY);

  localparam pll_cfg_t BOOT_CFG = '{idiv: BOOT_IDIV, fbdiv: BOOT_FBDIV,
                                    odsel: BOOT_ODSEL, psda: 4'h0, dutyda: 4'h0};

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  pll_state_e      state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [SB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [SB_W-1:0] stab_next;
  logic [AT_W-1:0] att_q, att_d;
  logic [7:0]      lost_q, lost_d;
  pll_cfg_t        cfg_q, cfg_d;
  pll_cfg_t        req_cfg;
  logic            err_q, err_d;
  logic            ready_q, locked_q, busy_q, pll_reset_q;
  logic            accept;

  assign req_cfg = '{idiv: req_idiv, fbdiv: req_fbdiv, odsel: req_odsel,
                     psda: req_psda, dutyda: req_dutyda};
  assign accept    = req_valid && ready_q;
  assign stab_next = stab_cnt_q + SB_W'(1);

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    to_cnt_d   = to_cnt_q;
    stab_cnt_d = stab_cnt_q;
    att_d      = att_q;
    lost_d     = lost_q;
    cfg_d      = cfg_q;
    err_d      = err_q;

    case (state_q)
      ST_RST: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d   = ST_WAIT_LOCK;
          rst_cnt_d = '0;
          to_cnt_d  = '0;
          att_d     = att_q + AT_W'(1);
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end

      ST_WAIT_LOCK, ST_QUALIFY: begin
        // The timeout window spans both states and takes priority over lock
        // progress, so a lock that only appears at the last cycle is retried.
        if (to_cnt_q == TO_LAST) begin
          if (att_q < AT_MAX) begin
            state_d = ST_RST;
          end else begin
            state_d = ST_FAIL;
            err_d   = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (state_q == ST_WAIT_LOCK) begin
            // This sample counts as the first of the LOCK_STABLE samples.
            if (lock_s) begin
              state_d    = ST_QUALIFY;
              stab_cnt_d = '0;
            end
          end else if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            stab_cnt_d = stab_next;
            if (stab_next == SB_LAST) begin
              state_d = ST_LOCKED;
            end
          end
        end
      end

      ST_LOCKED: begin
        if (!lock_s) begin
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
          state_d = ST_RST;
          att_d   = '0;
        end
      end

      ST_FAIL: begin
        err_d = 1'b1;
      end

      default: begin
        state_d = ST_RST;
      end
    endcase

    // A request overrides any concurrent lock-loss transition; the loss
    // itself has already been counted above.
    if (accept) begin
      state_d   = ST_RST;
      rst_cnt_d = '0;
      att_d     = '0;
      cfg_d     = encode_cfg(req_cfg);
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stab_cnt_q  <= '0;
      att_q       <= '0;
      lost_q      <= '0;
      cfg_q       <= encode_cfg(BOOT_CFG);
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      pll_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      att_q       <= att_d;
      lost_q      <= lost_d;
      cfg_q       <= cfg_d;
      err_q       <= err_d;
      // Outputs decode the next state so they align with the state register.
      ready_q     <= (state_d == ST_LOCKED) || (state_d == ST_FAIL);
      locked_q    <= (state_d == ST_LOCKED);
      busy_q      <= (state_d == ST_RST) || (state_d == ST_WAIT_LOCK) ||
                     (state_d == ST_QUALIFY);
      pll_reset_q <= (state_d == ST_RST) || (state_d == ST_FAIL);
    end
  end

  assign req_ready     = ready_q;
  assign pll_reset     = pll_reset_q;
  assign pll_reset_p   = 1'b0;
  assign pll_idsel     = cfg_q.idiv;
  assign pll_fbdsel    = cfg_q.fbdiv;
  assign pll_odsel     = cfg_q.odsel;
  assign pll_psda      = cfg_q.psda;
  assign pll_dutyda    = cfg_q.dutyda;
  assign pll_fdly      = 4'hF;
  assign locked        = locked_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;
  assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed testbench for pll_reconfig_ctrl with shortened timing parameters.
// Cycle n is the interval after the n-th rising clk edge following release
// of rst; outputs are sampled and inputs driven on the falling edge.
module tb_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_idiv, req_fbdiv, req_odsel;
  logic [3:0] req_psda, req_dutyda;
  logic       pll_lock;
  logic       pll_reset, pll_reset_p;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [3:0] pll_psda, pll_dutyda, pll_fdly;
  logic       locked, busy, err_timeout;
  logic [7:0] lock_lost_cnt;

  // {pll_reset, locked, busy, req_ready, err_timeout}
  logic [4:0] st;
  assign st = {pll_reset, locked, busy, req_ready, err_timeout};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (100),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_idiv      (req_idiv),
    .req_fbdiv     (req_fbdiv),
    .req_odsel     (req_odsel),
    .req_psda      (req_psda),
    .req_dutyda    (req_dutyda),
    .pll_lock      (pll_lock),
    .pll_reset     (pll_reset),
    .pll_reset_p   (pll_reset_p),
    .pll_idsel     (pll_idsel),
    .pll_fbdsel    (pll_fbdsel),
    .pll_odsel     (pll_odsel),
    .pll_psda      (pll_psda),
    .pll_dutyda    (pll_dutyda),
    .pll_fdly      (pll_fdly),
    .locked        (locked),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .lock_lost_cnt (lock_lost_cnt)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_cycle(input int k);
    while (cyc < k) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; pll_lock = 1'b0; req_valid = 1'b0;
    req_idiv = '0; req_fbdiv = '0; req_odsel = '0; req_psda = '0; req_dutyda = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (st !== 5'b10100) begin
      errors++; $display("FAIL reset_status st=%b exp=10100", st);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda} !== {6'h3E, 6'h35, 6'h08, 4'h0, 4'h0}) begin
      errors++; $display("FAIL reset_selects id=%h fb=%h od=%h ps=%h du=%h exp 3e 35 08 0 0",
                          pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda);
    end
    checks++;
    if ({pll_reset_p, pll_fdly, lock_lost_cnt, st} !== {1'b0, 4'hF, 8'd0, 5'b10100}) begin
      errors++; $display("FAIL reset_misc rp=%b fdly=%h lost=%0d st=%b exp 0 f 0 10100",
                          pll_reset_p, pll_fdly, lock_lost_cnt, st);
    end
    rst = 1'b0;
    cyc = 0;
    #1;
    checks++;
    if (pll_reset !== 1'b1) begin
      errors++; $display("FAIL boot_reset_c0 pll_reset=%b exp=1", pll_reset);
    end
  endtask

  task automatic test_boot();
    wait_cycle(3);
    checks++;
    if (pll_reset !== 1'b1) begin
      errors++; $display("FAIL boot_reset_c3 pll_reset=%b exp=1", pll_reset);
    end
    wait_cycle(4);
    checks++;
    if (st !== 5'b00100) begin
      errors++; $display("FAIL boot_wait_c4 st=%b exp=00100", st);
    end
    wait_cycle(20);
    pll_lock = 1'b1;
    wait_cycle(29);
    checks++;
    if (st !== 5'b00100) begin
      errors++; $display("FAIL boot_early_c29 st=%b exp=00100", st);
    end
    wait_cycle(30);
    checks++;
    if (st !== 5'b01010) begin
      errors++; $display("FAIL boot_locked_c30 st=%b exp=01010", st);
    end
    wait_cycle(38);
    checks++;
    if ({st, pll_idsel, pll_fbdsel} !== {5'b01010, 6'h3E, 6'h35}) begin
      errors++; $display("FAIL boot_hold st=%b id=%h fb=%h exp 01010 3e 35", st, pll_idsel, pll_fbdsel);
    end
  endtask

  task automatic test_lock_loss();
    int b;
    b = cyc;
    pll_lock = 1'b0;
    wait_cycle(b + 2);
    checks++;
    if (st !== 5'b01010) begin
      errors++; $display("FAIL loss_plus2 st=%b exp=01010", st);
    end
    wait_cycle(b + 3);
    checks++;
    if ({st, lock_lost_cnt} !== {5'b10100, 8'd1}) begin
      errors++; $display("FAIL loss_plus3 st=%b lost=%0d exp 10100 1", st, lock_lost_cnt);
    end
    pll_lock = 1'b1;
    wait_cycle(b + 14);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL relock_early locked=%b exp=0", locked);
    end
    wait_cycle(b + 15);
    checks++;
    if (st !== 5'b01010) begin
      errors++; $display("FAIL relock st=%b exp=01010", st);
    end
  endtask

  task automatic test_glitch();
    int b, r;
    b = cyc;
    pll_lock = 1'b0;
    r = b + 8;
    wait_cycle(r);
    pll_lock = 1'b1;
    wait_cycle(r + 5);
    pll_lock = 1'b0;
    wait_cycle(r + 6);
    pll_lock = 1'b1;
    wait_cycle(r + 7);
    checks++;
    if (st !== 5'b00100) begin
      errors++; $display("FAIL glitch_mid st=%b exp=00100", st);
    end
    wait_cycle(r + 15);
    checks++;
    if (st !== 5'b00100) begin
      errors++; $display("FAIL glitch_early st=%b exp=00100", st);
    end
    wait_cycle(r + 16);
    checks++;
    if ({st, lock_lost_cnt} !== {5'b01010, 8'd2}) begin
      errors++; $display("FAIL glitch_lock st=%b lost=%0d exp 01010 2", st, lock_lost_cnt);
    end
  endtask

  task automatic test_reconfig();
    req_idiv = 6'd3; req_fbdiv = 6'd20; req_odsel = 6'd5; req_psda = 4'h7; req_dutyda = 4'h9;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    pll_lock = 1'b0;
    t_acc = cyc;
    checks++;
    if ({pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda} !== {6'h3C, 6'h2B, 6'h05, 4'h7, 4'h9}) begin
      errors++; $display("FAIL reconfig_selects id=%h fb=%h od=%h ps=%h du=%h exp 3c 2b 05 7 9",
                          pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda);
    end
    checks++;
    if ({st, lock_lost_cnt} !== {5'b10100, 8'd2}) begin
      errors++; $display("FAIL reconfig_status st=%b lost=%0d exp 10100 2", st, lock_lost_cnt);
    end
  endtask

  task automatic test_timeout();
    int starts, highs;
    logic prev;
    prev = pll_reset;
    starts = 1; highs = 1;
    for (int k = 1; k <= 311; k++) begin
      tick();
      if (pll_reset && !prev) starts++;
      if (pll_reset) highs++;
      prev = pll_reset;
    end
    checks++;
    if (starts !== 3 || highs !== 12) begin
      errors++; $display("FAIL timeout_pulses starts=%0d highs=%0d exp 3 12", starts, highs);
    end
    checks++;
    if (st !== 5'b00100) begin
      errors++; $display("FAIL timeout_last_wait st=%b exp=00100", st);
    end
    tick();
    checks++;
    if (st !== 5'b10011) begin
      errors++; $display("FAIL timeout_fail st=%b exp=10011", st);
    end
    pll_lock = 1'b1;
    wait_cycle(t_acc + 325);
    checks++;
    if (st !== 5'b10011) begin
      errors++; $display("FAIL fail_sticky st=%b exp=10011", st);
    end
  endtask

  task automatic test_fail_exit();
    int d;
    req_idiv = 6'd2; req_fbdiv = 6'd7; req_odsel = 6'd4; req_psda = 4'h1; req_dutyda = 4'h2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    d = cyc;
    checks++;
    if ({st, pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda} !==
        {5'b10100, 6'h3D, 6'h38, 6'h04, 4'h1, 4'h2}) begin
      errors++; $display("FAIL fail_exit st=%b id=%h fb=%h od=%h ps=%h du=%h exp 10100 3d 38 04 1 2",
                          st, pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda);
    end
    wait_cycle(d + 11);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL fail_exit_early locked=%b exp=0", locked);
    end
    wait_cycle(d + 12);
    checks++;
    if ({st, lock_lost_cnt} !== {5'b01010, 8'd2}) begin
      errors++; $display("FAIL fail_exit_lock st=%b lost=%0d exp 01010 2", st, lock_lost_cnt);
    end
  endtask

  task automatic test_saturation();
    int b, n;
    logic [7:0] exp_cnt;
    for (int i = 1; i <= 300; i++) begin
      b = cyc;
      pll_lock = 1'b0;
      wait_cycle(b + 3);
      exp_cnt = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
      checks++;
      if ({pll_reset, locked, lock_lost_cnt} !== {1'b1, 1'b0, exp_cnt}) begin
        errors++; $display("FAIL sat_loss_%0d rst=%b lk=%b lost=%0d exp 1 0 %0d",
                            i, pll_reset, locked, lock_lost_cnt, exp_cnt);
      end
      pll_lock = 1'b1;
      n = 0;
      while (locked !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      if (locked !== 1'b1) begin
        checks++; errors++;
        $display("FAIL sat_relock_%0d locked=%b exp=1 within 40 cycles", i, locked);
        break;
      end
    end
    checks++;
    if ({locked, lock_lost_cnt} !== {1'b1, 8'd255}) begin
      errors++; $display("FAIL sat_final locked=%b lost=%0d exp 1 255", locked, lock_lost_cnt);
    end
  endtask

  task automatic test_reset_mid_qualify();
    int b;
    b = cyc;
    pll_lock = 1'b0;
    wait_cycle(b + 3);
    pll_lock = 1'b1;
    wait_cycle(b + 10);
    checks++;
    if (st !== 5'b00100) begin
      errors++; $display("FAIL qualify_state st=%b exp=00100", st);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({st, lock_lost_cnt} !== {5'b10100, 8'd0}) begin
      errors++; $display("FAIL midrst_status st=%b lost=%0d exp 10100 0", st, lock_lost_cnt);
    end
    checks++;
    if ({pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly, pll_reset_p} !==
        {6'h3E, 6'h35, 6'h08, 4'h0, 4'h0, 4'hF, 1'b0}) begin
      errors++; $display("FAIL midrst_selects id=%h fb=%h od=%h ps=%h du=%h fdly=%h rp=%b exp 3e 35 08 0 0 f 0",
                          pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly, pll_reset_p);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    wait_cycle(3);
    checks++;
    if (pll_reset !== 1'b1) begin
      errors++; $display("FAIL midrst_pulse_c3 pll_reset=%b exp=1", pll_reset);
    end
    wait_cycle(4);
    checks++;
    if (pll_reset !== 1'b0) begin
      errors++; $display("FAIL midrst_pulse_c4 pll_reset=%b exp=0", pll_reset);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_lock_loss();
    test_glitch();
    test_reconfig();
    test_timeout();
    test_fail_exit();
    test_saturation();
    test_reset_mid_qualify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Run-time controller for the GW1NR-9C rPLL dynamic-configuration port. The PLL wrapper ties IDSEL/FBDSEL/ODSEL/PSDA/DUTYDA/FDLY/RESET to ground; this block drives those inputs instead. It sequences PLL reset, lock acquisition, lock-stability qualification, timeout/retry and lock-loss recovery, and presents a valid/ready request port for new divider settings. It runs on the 27 MHz board clock that feeds the PLL `CLKIN`, never on a PLL output.

## Interface
- `RESET_CYCLES`, 16: cycles `pll_reset` is held high per reset attempt (≥2).
- `LOCK_TIMEOUT`, 65535: cycles allowed from reset release to qualified lock.
- `LOCK_STABLE`, 256: consecutive synchronized-lock-high cycles required to declare lock.
- `MAX_RETRY`, 3: reset attempts per request before failing.
- `BOOT_IDIV`, 1 / `BOOT_FBDIV`, 10 / `BOOT_ODSEL`, 6'd8: configuration applied out of reset.
- `clk` in 1: 27 MHz board clock.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: new configuration offered.
- `req_ready` out 1: block accepts a request this cycle.
- `req_idiv` in 6, `req_fbdiv` in 6: divider values, same meaning as the static `IDIV_SEL`/`FBDIV_SEL`.
- `req_odsel` in 6: output-divider device code, passed through unchanged.
- `req_psda` in 4, `req_dutyda` in 4: phase and duty codes, passed through unchanged.
- `pll_lock` in 1: raw rPLL `LOCK`, asynchronous to `clk`.
- `pll_reset` out 1: drives rPLL `RESET`.
- `pll_reset_p` out 1: drives rPLL `RESET_P`. Always 0.
- `pll_idsel` out 6, `pll_fbdsel` out 6, `pll_odsel` out 6, `pll_psda` out 4, `pll_dutyda` out 4: drive the rPLL dynamic selects.
- `pll_fdly` out 4: always 4'b1111.
- `locked` out 1: qualified lock.
- `busy` out 1: a reconfiguration is in progress.
- `err_timeout` out 1: sticky after `MAX_RETRY` failed attempts. Cleared by the next accepted request.
- `lock_lost_cnt` out 8: saturating count of lock losses seen in LOCKED.

## Operation
- Encoding: `pll_idsel = ~idiv` and `pll_fbdsel = ~fbdiv`, because the rPLL dynamic inputs are inverted. All other selects are passed straight through.
- Selects are registered. They change only in the cycle a request is accepted, and `pll_reset` is asserted from that cycle on.
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`.
- FSM states: RST, WAIT_LOCK, QUALIFY, LOCKED, FAIL.
- RST:
  - Assert `pll_reset`, count `RESET_CYCLES`.
  - Then go to WAIT_LOCK, clear the timeout counter and increment the attempt counter.
- WAIT_LOCK:
  - `pll_reset` = 0. Timeout counter increments every cycle.
  - `lock_s`=1 → QUALIFY with the stable counter cleared.
  - Timeout counter reaches `LOCK_TIMEOUT`-1: if attempts < `MAX_RETRY` → RST, otherwise → FAIL.
- QUALIFY:
  - Stable counter increments while `lock_s`=1. Reaching `LOCK_STABLE`-1 → LOCKED.
  - `lock_s`=0 → WAIT_LOCK. The timeout counter keeps running (not cleared).
  - Timeout expiry applies here exactly as in WAIT_LOCK.
- LOCKED:
  - `locked`=1, `req_ready`=1.
  - `lock_s` falls → `lock_lost_cnt`+1 (saturating at 255), attempts cleared, → RST with the same configuration.
  - Accepted request → RST with the new configuration, attempts cleared.
  - If both happen in the same cycle, the request wins, and the lock loss is still counted.
- FAIL:
  - `err_timeout`=1, `busy`=0, `req_ready`=1, `pll_reset` held at 1.
  - Only an accepted request exits FAIL.
- `busy` = state ∈ {RST, WAIT_LOCK, QUALIFY}. `req_ready` = state ∈ {LOCKED, FAIL}.

## Timing
- Reset values while `rst`=1:
  - State RST, counters 0.
  - `pll_reset`=1, `pll_reset_p`=0, selects = boot configuration (encoded), `pll_fdly`=4'hF.
  - `locked`=0, `busy`=1, `req_ready`=0, `err_timeout`=0, `lock_lost_cnt`=0.
- After `rst` deasserts, `pll_reset` stays high for exactly `RESET_CYCLES` cycles.
- Lock detection: 2 synchronizer cycles plus `LOCK_STABLE` cycles, so `locked` rises `LOCK_STABLE`+2 cycles after `pll_lock` rises and stays high.
- Lock loss: `locked` falls and `pll_reset` rises 3 cycles after `pll_lock` falls.
- Handshake: a request is accepted on the edge where `req_valid && req_ready`.
  - Next cycle: selects updated, `pll_reset`=1, `locked`=0, `req_ready`=0.
- Counter widths are `$clog2(param+1)`. No counter wraps.
- `rst` asserted mid-sequence aborts immediately to the reset values.

## Structure
- Package `pll_ctrl_pkg` holds:
  - the state enum;
  - the `pll_cfg_t` struct (idiv, fbdiv, odsel, psda, dutyda);
  - the `encode_cfg` function that applies the inversion.
- Sub-module `sync_2ff` (1-bit, async-reset-to-0) is used for `pll_lock`.

## Test plan
Simulation parameters: `RESET_CYCLES`=4, `LOCK_TIMEOUT`=100, `LOCK_STABLE`=8, `MAX_RETRY`=3.
- Boot: release `rst`, raise `pll_lock` at cycle 20 → `pll_reset` high cycles 0-3, `pll_idsel`=6'h3E, `pll_fbdsel`=6'h35, `locked`=1 at cycle 30.
- Glitch: lock high 5 cycles, low 1 cycle, then high → `locked` rises 10 cycles after the final rise, not earlier.
- Timeout: `pll_lock` held 0 → three reset pulses, then `err_timeout`=1, `req_ready`=1, `busy`=0, `pll_reset`=1.
- Reconfig: in LOCKED, send idiv=3, fbdiv=20 → next cycle `pll_idsel`=6'h3C, `pll_fbdsel`=6'h2B, `pll_reset`=1, `locked`=0, `err_timeout` cleared.
- Lock loss: drop `pll_lock` in LOCKED → `lock_lost_cnt`=1 and `pll_reset`=1 at +3 cycles. Repeat 300 losses → `lock_lost_cnt` saturates at 255.
- Reset mid-QUALIFY: `rst` pulse → all outputs at reset values in the same cycle.
